if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//   Parametrised instruction fetch queue between the fetch stage and decode; successor to the single-stage IF register.
//   Accepts a bundle of up to FETCH_WIDTH {inst, pc} slots per cycle and buffers them in a DEPTH-entry circular queue.
//   Presents the oldest up to FETCH_WIDTH entries to decode, which retires 0..FETCH_WIDTH of them per cycle.
//   Decouples fetch stalls from decode stalls; flush empties the queue in one cycle.
// PARAMETERS
//   FETCH_WIDTH  2   slots per enqueue bundle and per dequeue window (1..4)
//   DEPTH        8   queue entries; power of two, >= 2*FETCH_WIDTH
//   INST_W       32  instruction width
//   PC_W         32  pc width
// PORTS
//   clk        in   1                   clock, all state on posedge
//   rst        in   1                   asynchronous, active-high reset
//   flush      in   1                   synchronous queue clear (redirect/exception)
//   in_valid   in   FETCH_WIDTH         per-slot valid; must be contiguous from slot 0 (e.g. 2'b01, 2'b11)
//   in_inst    in   FETCH_WIDTH*INST_W  slot i at [i*INST_W +: INST_W]
//   in_pc      in   FETCH_WIDTH*PC_W    slot i at [i*PC_W +: PC_W]
//   in_ready   out  1                   queue can take a full bundle this cycle
//   out_valid  out  FETCH_WIDTH         out_valid[i] = 1 iff count > i
//   out_inst   out  FETCH_WIDTH*INST_W  slot i = entry (head+i) mod DEPTH; 0 when out_valid[i]=0
//   out_pc     out  FETCH_WIDTH*PC_W    as out_inst
//   deq_cnt    in   $clog2(FETCH_WIDTH+1) entries decode retires this cycle; must be <= popcount(out_valid)
//   count_o    out  $clog2(DEPTH)+1     current occupancy (debug/perf)
// BEHAVIOUR
//   - Reset (async, rst=1): head=tail=0, count=0; out_valid=0, out_inst/out_pc=0, in_ready=1, count_o=0. Storage not reset.
//   - in_ready = (DEPTH - count) >= FETCH_WIDTH, from registered count only; same-cycle deq does not raise it (no comb in->out path).
//   - Enqueue when in_ready & |in_valid: writes popcount(in_valid) entries at tail..tail+k-1 (mod DEPTH); tail += k.
//   - in_valid with in_ready=0 is dropped; fetch must hold its bundle (standard valid/ready).
//   - Dequeue: head += deq_cnt; deq_cnt > popcount(out_valid) is a protocol error, flagged by assertion; RTL clamps to count.
//   - count_next = count + k_enq - k_deq; simultaneous enq and deq both take effect in the same edge.
//   - Latency: entry written at edge N appears on out_* after edge N; no bypass when empty (min 1 cycle fetch->decode).
//   - Pointers are $clog2(DEPTH) bits and wrap naturally; full = count==DEPTH, empty = count==0.
//   - Flush: highest priority; at the edge head=tail=count=0; same-cycle enqueue and dequeue ignored; out_valid=0 next cycle.
//   - Non-contiguous in_valid (e.g. 2'b10) is illegal; assertion fires; RTL enqueues popcount slots taken from slot 0 upward.
//   - rst asserted mid-operation overrides everything immediately; deassertion synchronised externally.
// CONFIGURATION
//   IF_FETCH_QUEUE_EXC_EN:
//     defined   -> extra ports in_excp (in, FETCH_WIDTH*EXC_W) and out_excp (out, FETCH_WIDTH*EXC_W), EXC_W from package;
//                  per-entry fetch exception code (ADEF, TLB refill, PIF, PPI) stored and delivered alongside inst/pc;
//                  out_excp slot reads 0 when not valid; reset/flush behaviour identical to inst/pc.
//     undefined -> ports absent, no exception storage; fetch exceptions handled outside the queue.
// STRUCTURE
//   - if_pkg: FETCH_WIDTH/INST_W/PC_W defaults, EXC_W and exception code enum, typedef fetch_entry_t {inst, pc[, excp]}.
//   - Sub-module if_fq_ram: DEPTH x fetch_entry_t storage, FETCH_WIDTH write ports and FETCH_WIDTH async read ports.
//   - Top holds pointers, count, handshake, flush and output gating.
// TESTING
//   1 Reset: rst=1 mid-traffic -> same cycle out_valid=0, in_ready=1, count_o=0; after release, queue empty.
//   2 Fill: in_valid=2'b11 each cycle, deq_cnt=0, DEPTH=8 -> count 2,4,6,8; in_ready low at count=8 (and from count=7); 5th bundle held, not lost.
//   3 Order/partial: enq {A,B}, then {C} (2'b01), deq_cnt=1 per cycle -> decode sees A,B,C in order; pcs match.
//   4 Simultaneous: count=6, enq 2 and deq 2 same cycle -> count stays 6, in_ready stays 1; head and tail both advance.
//   5 Wrap: 20 cycles enq 2 / deq 2 at DEPTH=8 -> pointers wrap 5 times, data intact, no spurious out_valid.
//   6 Flush: count=5, flush=1 with in_valid=2'b11 and deq_cnt=2 -> next cycle count=0, out_valid=0, nothing enqueued;
//     with IF_FETCH_QUEUE_EXC_EN, queued TLB-refill code cleared and later entries deliver their own excp.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// IF_FETCH_QUEUE_EXC_EN adds a per-entry fetch exception code to fetch_entry_t.
package if_pkg;

    localparam int FETCH_WIDTH_DEF = 2;
    localparam int DEPTH_DEF       = 8;
    localparam int INST_W_DEF      = 32;
    localparam int PC_W_DEF        = 32;
    localparam int EXC_W           = 3;

    typedef enum logic [EXC_W-1:0] {
        EXC_NONE = 3'd0,
        EXC_ADEF = 3'd1,
        EXC_TLBR = 3'd2,
        EXC_PIF  = 3'd3,
        EXC_PPI  = 3'd4
    } fetch_exc_e;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [PC_W_DEF-1:0]   pc;
`ifdef IF_FETCH_QUEUE_EXC_EN
        fetch_exc_e            excp;
`endif
    } fetch_entry_t;

    // Number of set bits in a (zero-extended) bundle valid vector.
    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/if_fq_checker.sv
// Protocol checks for the fetch queue: contiguous in_valid, legal deq_cnt, bounded occupancy.
module if_fq_checker #(
    parameter int FW    = 2,
    parameter int DEPTH = 8,
    parameter int CW    = 4,
    parameter int DW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic [FW-1:0] in_valid,
    input logic [DW-1:0] deq_cnt,
    input logic [CW-1:0] count
);

    logic [CW-1:0] win_s;

    // Size of the currently presented dequeue window.
    always_comb begin
        if (count < CW'(FW)) begin
            win_s = count;
        end else begin
            win_s = CW'(FW);
        end
    end

    a_in_valid_contig: assert property (@(posedge clk) disable iff (rst)
        ((in_valid & (in_valid + FW'(1))) == '0));

    a_deq_legal: assert property (@(posedge clk) disable iff (rst)
        (CW'(deq_cnt) <= win_s));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        (count <= CW'(DEPTH)));

endmodule

// File: rtl/if_fq_ram.sv
// Fetch queue storage: DEPTH entries, FW write ports and FW asynchronous read ports.
// Entries are stored as flat W-bit words; storage is intentionally not reset.
module if_fq_ram #(
    parameter int DEPTH = 8,
    parameter int FW    = 2,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [FW-1:0]     we,
    input  logic [FW*AW-1:0]  waddr,
    input  logic [FW*W-1:0]   wdata,
    input  logic [FW*AW-1:0]  raddr,
    output logic [FW*W-1:0]   rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write ports; the top guarantees enabled addresses are distinct.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FW; i++) begin
            if (we[i]) begin
                mem_q[waddr[i*AW +: AW]] <= wdata[i*W +: W];
            end
        end
    end

    // Asynchronous read ports.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < FW; i++) begin
            rdata[i*W +: W] = mem_q[raddr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between fetch and decode: circular buffer with multi-slot enq/deq.
// IF_FETCH_QUEUE_EXC_EN adds in_excp/out_excp carrying a per-entry fetch exception code.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int INST_W      = INST_W_DEF,
    parameter int PC_W        = PC_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [FETCH_WIDTH-1:0]            in_valid,
    input  logic [FETCH_WIDTH*INST_W-1:0]     in_inst,
    input  logic [FETCH_WIDTH*PC_W-1:0]       in_pc,
    output logic                              in_ready,
    output logic [FETCH_WIDTH-1:0]            out_valid,
    output logic [FETCH_WIDTH*INST_W-1:0]     out_inst,
    output logic [FETCH_WIDTH*PC_W-1:0]       out_pc,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]  deq_cnt,
`ifdef IF_FETCH_QUEUE_EXC_EN
    input  logic [FETCH_WIDTH*EXC_W-1:0]      in_excp,
    output logic [FETCH_WIDTH*EXC_W-1:0]      out_excp,
`endif
    output logic [$clog2(DEPTH):0]            count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(FETCH_WIDTH + 1);
`ifdef IF_FETCH_QUEUE_EXC_EN
    localparam int XW = EXC_W;
`else
    localparam int XW = 0;
`endif
    localparam int EW = INST_W + PC_W + XW;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [3:0]                 in_valid_ext_s;
    logic                       in_ready_s;
    logic                       enq_s;
    logic [CW-1:0]              k_enq_s;
    logic [CW-1:0]              k_deq_s;
    logic [CW-1:0]              win_s;
    logic [FETCH_WIDTH-1:0]     we_s;
    logic [FETCH_WIDTH*AW-1:0]  waddr_s;
    logic [FETCH_WIDTH*EW-1:0]  wdata_s;
    logic [FETCH_WIDTH*AW-1:0]  raddr_s;
    logic [FETCH_WIDTH*EW-1:0]  rdata_s;

    // Handshake, enqueue/dequeue amounts and next pointer/count state.
    always_comb begin
        in_valid_ext_s                    = 4'b0000;
        in_valid_ext_s[FETCH_WIDTH-1:0]   = in_valid;
        // Ready depends only on registered occupancy, never on this cycle's dequeue.
        in_ready_s = ((CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH));
        enq_s      = in_ready_s && (|in_valid) && !flush;
        if (enq_s) begin
            k_enq_s = CW'(popcnt4(in_valid_ext_s));
        end else begin
            k_enq_s = '0;
        end
        if (count_q < CW'(FETCH_WIDTH)) begin
            win_s = count_q;
        end else begin
            win_s = CW'(FETCH_WIDTH);
        end
        if (CW'(deq_cnt) > win_s) begin
            k_deq_s = win_s;
        end else begin
            k_deq_s = CW'(deq_cnt);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(k_deq_s);
            tail_d  = tail_q + AW'(k_enq_s);
            count_d = count_q + k_enq_s - k_deq_s;
        end
    end

    // RAM port addressing; an illegal sparse bundle still writes from slot 0 upward.
    always_comb begin
        we_s    = '0;
        waddr_s = '0;
        wdata_s = '0;
        raddr_s = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            we_s[i]              = enq_s && (k_enq_s > CW'(i));
            waddr_s[i*AW +: AW]  = tail_q + AW'(i);
            raddr_s[i*AW +: AW]  = head_q + AW'(i);
`ifdef IF_FETCH_QUEUE_EXC_EN
            wdata_s[i*EW +: EW]  = {in_inst[i*INST_W +: INST_W], in_pc[i*PC_W +: PC_W],
                                    in_excp[i*EXC_W +: EXC_W]};
`else
            wdata_s[i*EW +: EW]  = {in_inst[i*INST_W +: INST_W], in_pc[i*PC_W +: PC_W]};
`endif
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    if_fq_ram #(
        .DEPTH (DEPTH),
        .FW    (FETCH_WIDTH),
        .W     (EW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Decode window, gated to zero for slots beyond the current occupancy.
    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
`ifdef IF_FETCH_QUEUE_EXC_EN
        out_excp  = '0;
`endif
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            out_valid[i] = (count_q > CW'(i));
            if (out_valid[i]) begin
                out_inst[i*INST_W +: INST_W] = rdata_s[i*EW + PC_W + XW +: INST_W];
                out_pc[i*PC_W +: PC_W]       = rdata_s[i*EW + XW +: PC_W];
`ifdef IF_FETCH_QUEUE_EXC_EN
                out_excp[i*EXC_W +: EXC_W]   = rdata_s[i*EW +: EXC_W];
`endif
            end else begin
                out_inst[i*INST_W +: INST_W] = '0;
                out_pc[i*PC_W +: PC_W]       = '0;
            end
        end
    end

    assign in_ready = in_ready_s;
    assign count_o  = count_q;

    if_fq_checker #(
        .FW    (FETCH_WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW),
        .DW    (DW)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .deq_cnt  (deq_cnt),
        .count    (count_q)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed, table-driven bench for if_fetch_queue (FETCH_WIDTH=2, DEPTH=8).
module tb_if_fetch_queue;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [1:0]  deq_cnt;
    logic [3:0]  count_o;
`ifdef IF_FETCH_QUEUE_EXC_EN
    logic [5:0]  in_excp;
    logic [5:0]  out_excp;
`endif

    int n_vec = 0;
    int n_bad = 0;

    if_fetch_queue #(.FETCH_WIDTH(2), .DEPTH(8), .INST_W(32), .PC_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .deq_cnt   (deq_cnt),
`ifdef IF_FETCH_QUEUE_EXC_EN
        .in_excp   (in_excp),
        .out_excp  (out_excp),
`endif
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [1:0]  vld;
        logic [31:0] base;
        logic [1:0]  deq;
        logic [3:0]  cnt;
        logic        rdy;
        logic [1:0]  ov;
        logic [31:0] i0;
        logic [31:0] i1;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [31:0] pc_of(input logic [31:0] t);
        pc_of = 32'h8000_0000 + (t << 2);
    endfunction

    function automatic logic [2:0] exc_of(input logic [31:0] t);
        exc_of = 3'(t % 32'd5);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [1:0] v, input logic [31:0] base,
                         input logic [1:0] d);
        flush    = fl;
        in_valid = v;
        deq_cnt  = d;
        in_inst  = {base + 32'd1, base};
        in_pc    = {pc_of(base + 32'd1), pc_of(base)};
`ifdef IF_FETCH_QUEUE_EXC_EN
        in_excp  = {exc_of(base + 32'd1), exc_of(base)};
`endif
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic rdy,
                             input logic [1:0] ov, input logic [31:0] i0, input logic [31:0] i1);
        chk({tag, ".count"}, 32'(count_o), 32'(cnt));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".inst0"}, out_inst[31:0], i0);
        chk({tag, ".inst1"}, out_inst[63:32], i1);
        chk({tag, ".pc0"}, out_pc[31:0], ov[0] ? pc_of(i0) : 32'd0);
        chk({tag, ".pc1"}, out_pc[63:32], ov[1] ? pc_of(i1) : 32'd0);
`ifdef IF_FETCH_QUEUE_EXC_EN
        chk({tag, ".excp0"}, 32'(out_excp[2:0]), ov[0] ? 32'(exc_of(i0)) : 32'd0);
        chk({tag, ".excp1"}, 32'(out_excp[5:3]), ov[1] ? 32'(exc_of(i1)) : 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           flush vld    base    deq   cnt    rdy   ov     i0      i1
        tbl[0]  = '{1'b0, 2'b11, 32'h10, 2'd0, 4'd2, 1'b1, 2'b11, 32'h10, 32'h11};
        tbl[1]  = '{1'b0, 2'b11, 32'h20, 2'd0, 4'd4, 1'b1, 2'b11, 32'h10, 32'h11};
        tbl[2]  = '{1'b0, 2'b11, 32'h30, 2'd0, 4'd6, 1'b1, 2'b11, 32'h10, 32'h11};
        tbl[3]  = '{1'b0, 2'b01, 32'h40, 2'd0, 4'd7, 1'b0, 2'b11, 32'h10, 32'h11};
        tbl[4]  = '{1'b0, 2'b11, 32'h50, 2'd1, 4'd6, 1'b1, 2'b11, 32'h11, 32'h20};
        tbl[5]  = '{1'b0, 2'b11, 32'h50, 2'd0, 4'd8, 1'b0, 2'b11, 32'h11, 32'h20};
        tbl[6]  = '{1'b0, 2'b11, 32'h60, 2'd0, 4'd8, 1'b0, 2'b11, 32'h11, 32'h20};
        tbl[7]  = '{1'b0, 2'b00, 32'h00, 2'd2, 4'd6, 1'b1, 2'b11, 32'h21, 32'h30};
        tbl[8]  = '{1'b0, 2'b11, 32'h70, 2'd2, 4'd6, 1'b1, 2'b11, 32'h31, 32'h40};
        tbl[9]  = '{1'b0, 2'b00, 32'h00, 2'd2, 4'd4, 1'b1, 2'b11, 32'h50, 32'h51};
        tbl[10] = '{1'b0, 2'b00, 32'h00, 2'd2, 4'd2, 1'b1, 2'b11, 32'h70, 32'h71};
        tbl[11] = '{1'b0, 2'b00, 32'h00, 2'd1, 4'd1, 1'b1, 2'b01, 32'h71, 32'h00};
        tbl[12] = '{1'b0, 2'b00, 32'h00, 2'd1, 4'd0, 1'b1, 2'b00, 32'h00, 32'h00};
        tbl[13] = '{1'b0, 2'b01, 32'h80, 2'd0, 4'd1, 1'b1, 2'b01, 32'h80, 32'h00};
        tbl[14] = '{1'b0, 2'b00, 32'h00, 2'd0, 4'd1, 1'b1, 2'b01, 32'h80, 32'h00};

        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 2'd0);
        #3;
        chk_state("reset", 4'd0, 1'b1, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_state("post_reset", 4'd0, 1'b1, 2'b00, 32'd0, 32'd0);

        for (int v = 0; v < 15; v++) begin
            drive(tbl[v].flush, tbl[v].vld, tbl[v].base, tbl[v].deq);
            step();
            chk_state($sformatf("vec%0d", v), tbl[v].cnt, tbl[v].rdy, tbl[v].ov,
                      tbl[v].i0, tbl[v].i1);
        end

        // Bring occupancy from 1 to 5, then flush with a competing enqueue and dequeue.
        drive(1'b0, 2'b11, 32'h90, 2'd0);
        step();
        drive(1'b0, 2'b11, 32'hA0, 2'd0);
        step();
        chk_state("pre_flush", 4'd5, 1'b1, 2'b11, 32'h80, 32'h90);
        drive(1'b1, 2'b11, 32'hB0, 2'd2);
        step();
        chk_state("flush", 4'd0, 1'b1, 2'b00, 32'd0, 32'd0);
        drive(1'b0, 2'b00, 32'h0, 2'd0);
        step();
        chk_state("flush_hold", 4'd0, 1'b1, 2'b00, 32'd0, 32'd0);

        // Steady enq 2 / deq 2 for 20 cycles: pointers wrap five times.
        drive(1'b0, 2'b11, 32'h100, 2'd0);
        step();
        chk_state("wrap_pre", 4'd2, 1'b1, 2'b11, 32'h100, 32'h101);
        for (int j = 0; j < 20; j++) begin
            drive(1'b0, 2'b11, 32'h100 + 32'(j + 1) * 32'h10, 2'd2);
            step();
            chk_state($sformatf("wrap%0d", j), 4'd2, 1'b1, 2'b11,
                      32'h100 + 32'(j + 1) * 32'h10, 32'h101 + 32'(j + 1) * 32'h10);
        end

        // Asynchronous reset in the middle of traffic takes effect without a clock edge.
        drive(1'b0, 2'b11, 32'h300, 2'd0);
        step();
        chk("pre_rst.count", 32'(count_o), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk_state("mid_rst", 4'd0, 1'b1, 2'b00, 32'd0, 32'd0);
        drive(1'b0, 2'b00, 32'h0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_state("after_rst", 4'd0, 1'b1, 2'b00, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
